// File: rtl/rf_wbarb_pkg.sv
//------------------------------------------------------------------------------
// Module   : rf_wbarb_pkg
// Brief    : Shared widths, defaults and types for the write-back arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rf_wbarb_pkg;

    localparam int WORDSZ        = 32;
    localparam int RFSZLOG2      = 5;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_SLACK = 5;

    typedef struct packed {
        logic [RFSZLOG2-1:0] rn;
        logic [WORDSZ-1:0]   res;
    } wb_entry_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    function automatic logic is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wbarb_if.sv
//------------------------------------------------------------------------------
// Module   : rf_wbarb_if
// Brief    : Result inputs and register-file write port of the arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rf_wbarb_if;

    logic [rf_wbarb_pkg::RFSZLOG2-1:0] a_rn;
    logic [rf_wbarb_pkg::WORDSZ-1:0]   a_res;
    logic [rf_wbarb_pkg::RFSZLOG2-1:0] b_rn;
    logic [rf_wbarb_pkg::WORDSZ-1:0]   b_res;
    logic                              a_afull;
    logic                              b_afull;
    logic                              w_we;
    logic [rf_wbarb_pkg::RFSZLOG2-1:0] w_addr;
    logic [rf_wbarb_pkg::WORDSZ-1:0]   w_data;
    logic                              w_rdy;
    logic                              ovf;

    modport slave (
        input  a_rn, a_res, b_rn, b_res, w_rdy,
        output a_afull, b_afull, w_we, w_addr, w_data, ovf
    );

    modport master (
        output a_rn, a_res, b_rn, b_res, w_rdy,
        input  a_afull, b_afull, w_we, w_addr, w_data, ovf
    );

endinterface

`default_nettype wire

// File: rtl/rf_wbarb_wb_fifo.sv
//------------------------------------------------------------------------------
// Module   : wb_fifo
// Brief    : Show-ahead result FIFO with registered almost-full and drop flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_fifo
    import rf_wbarb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SLACK = DEFAULT_SLACK
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire wb_entry_t                  din,
    output wb_entry_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty,
    output logic                            afull,
    output logic                            drop
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [PTRW-1:0] wptr_q, wptr_d;
    logic [PTRW-1:0] rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            afull_q, afull_d;
    logic            do_push;
    logic            do_pop;
    wb_entry_t       mem_q [DEPTH];

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNTW'(DEPTH));
        do_pop  = pop && !empty;
        // A full FIFO still takes a push when the same edge frees a slot.
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
        afull_d = (CNTW'(DEPTH) - count_d) <= CNTW'(SLACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            afull_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            afull_q <= afull_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;
    assign afull = afull_q;

endmodule

`default_nettype wire

// File: rtl/rf_wbarb.sv
//------------------------------------------------------------------------------
// Module   : rf_wbarb
// Brief    : Two-source round-robin register-file write-back arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_wbarb
    import rf_wbarb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SLACK = DEFAULT_SLACK
) (
    input  wire logic   clk,
    input  wire logic   rst,
    rf_wbarb_if.slave   wb
);

    localparam int CNTW = $clog2(DEPTH + 1);

    if (!is_pow2(DEPTH) || (DEPTH < 8)) begin : g_bad_depth
        $fatal(1, "rf_wbarb: DEPTH must be a power of two and at least 8");
    end

    wb_entry_t       din_a, din_b;
    wb_entry_t       head_a, head_b, head_sel;
    logic [CNTW-1:0] count_a, count_b;
    logic            full_a, full_b;
    logic            empty_a, empty_b;
    logic            afull_a, afull_b;
    logic            drop_a, drop_b;
    logic            push_a, push_b;
    logic            pop_a, pop_b;
    logic            any_valid;
    logic            fire;
    src_e            sel;

    src_e            last_src_q, last_src_d;
    logic            lock_q, lock_d;
    src_e            lock_src_q, lock_src_d;
    logic            ovf_q, ovf_d;

    assign push_a = (wb.a_rn != '0) && !rst;
    assign push_b = (wb.b_rn != '0) && !rst;
    assign din_a  = '{rn: wb.a_rn, res: wb.a_res};
    assign din_b  = '{rn: wb.b_rn, res: wb.b_res};

    wb_fifo #(.DEPTH(DEPTH), .SLACK(SLACK)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .pop   (pop_a),
        .din   (din_a),
        .head  (head_a),
        .count (count_a),
        .full  (full_a),
        .empty (empty_a),
        .afull (afull_a),
        .drop  (drop_a)
    );

    wb_fifo #(.DEPTH(DEPTH), .SLACK(SLACK)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .pop   (pop_b),
        .din   (din_b),
        .head  (head_b),
        .count (count_b),
        .full  (full_b),
        .empty (empty_b),
        .afull (afull_b),
        .drop  (drop_b)
    );

    always_comb begin
        any_valid = !empty_a || !empty_b;
        // A stalled write keeps its source so the port stays stable.
        if (lock_q) begin
            sel = lock_src_q;
        end else if (!empty_a && !empty_b) begin
            sel = (last_src_q == SRC_B) ? SRC_A : SRC_B;
        end else if (!empty_a) begin
            sel = SRC_A;
        end else begin
            sel = SRC_B;
        end
        head_sel   = (sel == SRC_A) ? head_a : head_b;
        fire       = any_valid && wb.w_rdy;
        pop_a      = fire && (sel == SRC_A);
        pop_b      = fire && (sel == SRC_B);
        last_src_d = fire ? sel : last_src_q;
        lock_d     = any_valid && !wb.w_rdy;
        lock_src_d = sel;
        ovf_d      = ovf_q || drop_a || drop_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_src_q <= SRC_B;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_A;
            ovf_q      <= 1'b0;
        end else begin
            last_src_q <= last_src_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            ovf_q      <= ovf_d;
        end
    end

    assign wb.w_we    = any_valid;
    assign wb.w_addr  = any_valid ? head_sel.rn  : '0;
    assign wb.w_data  = any_valid ? head_sel.res : '0;
    assign wb.a_afull = afull_a;
    assign wb.b_afull = afull_b;
    assign wb.ovf     = ovf_q;

    // Full flags and counts are observed only through afull/drop at this level.
    logic unused_ok;
    assign unused_ok = &{1'b0, full_a, full_b, count_a, count_b};

endmodule

`default_nettype wire

// File: tb/tb_rf_wbarb.sv
//------------------------------------------------------------------------------
// Module   : tb_rf_wbarb
// Brief    : Directed self-checking bench for the write-back arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_wbarb;
    import rf_wbarb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    rf_wbarb_if bus ();

    rf_wbarb u_dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        bus.a_rn   = '0;
        bus.a_res  = '0;
        bus.b_rn   = '0;
        bus.b_res  = '0;
        bus.w_rdy  = 1'b0;
        tick();
        tick();
        check("rst_we",    64'(bus.w_we),    64'd0);
        check("rst_addr",  64'(bus.w_addr),  64'd0);
        check("rst_data",  64'(bus.w_data),  64'd0);
        check("rst_afa",   64'(bus.a_afull), 64'd0);
        check("rst_afb",   64'(bus.b_afull), 64'd0);
        check("rst_ovf",   64'(bus.ovf),     64'd0);
        rst = 1'b0;
        tick();

        // Single entry, one-cycle latency.
        bus.w_rdy = 1'b1;
        bus.a_rn  = 5'd3;
        bus.a_res = 32'h15;
        tick();
        bus.a_rn  = '0;
        check("lat_we",   64'(bus.w_we),   64'd1);
        check("lat_addr", 64'(bus.w_addr), 64'd3);
        check("lat_data", 64'(bus.w_data), 64'h15);
        tick();
        check("lat_idle", 64'(bus.w_we),   64'd0);

        // Round-robin ties starting from a fresh reset.
        do_reset();
        bus.w_rdy = 1'b1;
        bus.a_rn = 5'd1; bus.a_res = 32'h11;
        bus.b_rn = 5'd2; bus.b_res = 32'h22;
        tick();
        bus.a_rn = '0; bus.b_rn = '0;
        check("rr_first",  64'(bus.w_addr), 64'd1);
        check("rr_first_d",64'(bus.w_data), 64'h11);
        tick();
        check("rr_second", 64'(bus.w_addr), 64'd2);
        check("rr_sec_d",  64'(bus.w_data), 64'h22);
        bus.a_rn = 5'd4; bus.a_res = 32'h44;
        bus.b_rn = 5'd5; bus.b_res = 32'h55;
        tick();
        bus.a_rn = '0; bus.b_rn = '0;
        check("rr_tie2_a", 64'(bus.w_addr), 64'd4);
        tick();
        check("rr_tie2_b", 64'(bus.w_addr), 64'd5);
        tick();
        check("rr_idle",   64'(bus.w_we),   64'd0);

        // Stalled write holds its source while the other FIFO fills.
        bus.w_rdy = 1'b0;
        bus.b_rn = 5'd7; bus.b_res = 32'h77;
        tick();
        bus.b_rn = '0;
        bus.a_rn = 5'd9; bus.a_res = 32'h99;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.a_rn = '0;
            check("lock_addr", 64'(bus.w_addr), 64'd7);
            check("lock_data", 64'(bus.w_data), 64'h77);
        end
        bus.w_rdy = 1'b1;
        #1;
        check("lock_rel",  64'(bus.w_addr), 64'd7);
        tick();
        check("lock_next", 64'(bus.w_addr), 64'd9);
        check("lock_nd",   64'(bus.w_data), 64'h99);
        tick();
        check("lock_idle", 64'(bus.w_we),   64'd0);

        // Fill past capacity, then drain in order.
        do_reset();
        bus.w_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.a_rn  = 5'(i + 1);
            bus.a_res = 32'h100 + 32'(i);
            tick();
            check("fill_afull", 64'(bus.a_afull), 64'((i + 1) >= 3));
            check("fill_ovf",   64'(bus.ovf),     64'(i == 8));
        end
        bus.a_rn  = '0;
        bus.w_rdy = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("drain_addr", 64'(bus.w_addr), 64'(j + 1));
            check("drain_data", 64'(bus.w_data), 64'(32'h100 + 32'(j)));
            tick();
        end
        check("drain_idle",  64'(bus.w_we),    64'd0);
        check("drain_afull", 64'(bus.a_afull), 64'd0);
        check("drain_ovf",   64'(bus.ovf),     64'd1);

        // Push and pop together on a full FIFO.
        do_reset();
        bus.w_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.a_rn  = 5'(i + 1);
            bus.a_res = 32'h200 + 32'(i);
            tick();
        end
        check("pp_cnt0", 64'(u_dut.u_fifo_a.count_q), 64'd8);
        bus.w_rdy = 1'b1;
        bus.a_rn  = 5'd10;
        bus.a_res = 32'h2FF;
        tick();
        bus.a_rn  = '0;
        check("pp_cnt",   64'(u_dut.u_fifo_a.count_q), 64'd8);
        check("pp_ovf",   64'(bus.ovf),     64'd0);
        check("pp_afull", 64'(bus.a_afull), 64'd1);
        for (int j = 0; j < 8; j++) begin
            check("pp_addr", 64'(bus.w_addr), (j < 7) ? 64'(j + 2) : 64'd10);
            tick();
        end
        check("pp_idle", 64'(bus.w_we), 64'd0);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        bus.w_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.a_rn  = 5'(11 + i);
            bus.a_res = 32'h300 + 32'(i);
            tick();
        end
        bus.a_rn  = '0;
        bus.w_rdy = 1'b1;
        tick();
        check("mid_we",   64'(bus.w_we),   64'd1);
        check("mid_addr", 64'(bus.w_addr), 64'd12);
        #2;
        rst      = 1'b1;
        bus.a_rn = 5'd5;
        #1;
        check("arst_we",   64'(bus.w_we),   64'd0);
        check("arst_addr", 64'(bus.w_addr), 64'd0);
        tick();
        tick();
        check("arst_hold", 64'(bus.w_we), 64'd0);
        rst      = 1'b0;
        bus.a_rn = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_we", 64'(bus.w_we), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
